// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module   : regfile
//  Brief    : 32 x 32-bit integer register file, two combinational read ports,
//             one write port, x0 hardwired to zero, committed-write counter.
//             Optional same-cycle write-through bypass on the read ports,
//             enabled by defining REGFILE_WRITE_FORWARD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module regfile (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    input  logic        rs1E_in,
    input  logic [4:0]  rs1Idx_in,
    input  logic        rs2E_in,
    input  logic [4:0]  rs2Idx_in,
    output logic [31:0] rs1Data_out,
    output logic [31:0] rs2Data_out,
    output logic [31:0] wbCount_out
);

    localparam int         c_NUM_REGS = 32;
    localparam logic [4:0] c_ZERO_IDX = 5'd0;

    logic [31:0] r_mem [c_NUM_REGS];
    logic [31:0] r_wb_count;

    // A write is architectural only when enabled, out of reset and not to x0.
    logic w_wr_commit;
    assign w_wr_commit = rdE_in && !rst_in && (rdIdx_in != c_ZERO_IDX);

    // Storage and commit counter; reset wins over any concurrent write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_wr_commit) begin
            r_mem[rdIdx_in] <= rdData_in;
            r_wb_count      <= r_wb_count + 32'd1;
        end
    end

    assign wbCount_out = r_wb_count;

    // One read port: zero when held in reset, disabled or addressing x0;
    // otherwise the stored entry, optionally bypassed by a same-cycle write.
    function automatic logic [31:0] read_port(
        input logic        en,
        input logic [4:0]  idx,
        input logic [31:0] stored
    );
        logic [31:0] v;
        v = '0;
        if (!rst_in && en && (idx != c_ZERO_IDX)) begin
`ifdef REGFILE_WRITE_FORWARD_EN
            // w_wr_commit already excludes x0, so index 0 never forwards.
            if (w_wr_commit && (rdIdx_in == idx)) begin
                v = rdData_in;
            end else begin
                v = stored;
            end
`else
            v = stored;
`endif
        end
        return v;
    endfunction

    // Read port 1, purely combinational.
    always_comb begin
        rs1Data_out = read_port(rs1E_in, rs1Idx_in, r_mem[rs1Idx_in]);
    end

    // Read port 2, purely combinational and independent of port 1.
    always_comb begin
        rs2Data_out = read_port(rs2E_in, rs2Idx_in, r_mem[rs2Idx_in]);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile
//  Brief    : Directed self-checking bench for regfile. Expectations follow
//             the REGFILE_WRITE_FORWARD_EN setting of the build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile;

    logic        clk_in;
    logic        rst_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        rs1E_in;
    logic [4:0]  rs1Idx_in;
    logic        rs2E_in;
    logic [4:0]  rs2Idx_in;
    logic [31:0] rs1Data_out;
    logic [31:0] rs2Data_out;
    logic [31:0] wbCount_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    regfile dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .rdData_in   (rdData_in),
        .rs1E_in     (rs1E_in),
        .rs1Idx_in   (rs1Idx_in),
        .rs2E_in     (rs2E_in),
        .rs2Idx_in   (rs2Idx_in),
        .rs1Data_out (rs1Data_out),
        .rs2Data_out (rs2Data_out),
        .wbCount_out (wbCount_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Watchdog: the directed sequence is short; never let the run hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] idx, input logic [31:0] data);
        rdE_in    = en;
        rdIdx_in  = idx;
        rdData_in = data;
    endtask

    task automatic set_rd(input logic e1, input logic [4:0] i1, input logic e2, input logic [4:0] i2);
        rs1E_in   = e1;
        rs1Idx_in = i1;
        rs2E_in   = e2;
        rs2Idx_in = i2;
    endtask

    initial begin
        logic [31:0] exp_fwd;

        rst_in = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);

        // Reset state: reads are forced to 0 while reset is high.
        tick();
        tick();
        set_rd(1'b1, 5'd5, 1'b1, 5'd31);
        #1;
        check("reset_rs1", rs1Data_out, 32'h0);
        check("reset_rs2", rs2Data_out, 32'h0);
        check("reset_count", wbCount_out, 32'h0);

        // Write x5, read it back the next cycle.
        rst_in = 1'b0;
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        check("x5_read", rs1Data_out, 32'hDEAD_BEEF);
        check("x5_count", wbCount_out, 32'd1);

        // Write to x0 is discarded and does not count.
        set_wr(1'b1, 5'd0, 32'h1234_5678);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        check("x0_rs1", rs1Data_out, 32'h0);
        check("x0_rs2", rs2Data_out, 32'h0);
        check("x0_count", wbCount_out, 32'd1);

        // Same-cycle write/read of x7 (previously 0x11).
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b1, 5'd7, 32'h0000_0011);
        tick();
        set_wr(1'b1, 5'd7, 32'hA5A5_A5A5);
        set_rd(1'b0, 5'd0, 1'b1, 5'd7);
`ifdef REGFILE_WRITE_FORWARD_EN
        exp_fwd = 32'hA5A5_A5A5;
`else
        exp_fwd = 32'h0000_0011;
`endif
        #1;
        check("x7_same_cycle", rs2Data_out, exp_fwd);
        // A same-cycle write to x0 never forwards under either setting.
        set_wr(1'b1, 5'd0, 32'hFFFF_0000);
        set_rd(1'b1, 5'd0, 1'b1, 5'd7);
        #1;
        check("x0_no_fwd", rs1Data_out, 32'h0);
        set_wr(1'b1, 5'd7, 32'hA5A5_A5A5);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd7, 1'b1, 5'd7);
        #1;
        check("x7_next_rs1", rs1Data_out, 32'hA5A5_A5A5);
        check("x7_next_rs2", rs2Data_out, 32'hA5A5_A5A5);
        check("x7_count", wbCount_out, 32'd3);

        // Write during reset is lost; storage and count are cleared.
        rst_in = 1'b1;
        #1;
        check("midrst_read_zero", rs1Data_out, 32'h0);
        set_wr(1'b1, 5'd3, 32'h0000_00FF);
        tick();
        rst_in = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd3, 1'b1, 5'd5);
        #1;
        check("rstwr_x3", rs1Data_out, 32'h0);
        check("rstwr_x5_cleared", rs2Data_out, 32'h0);
        check("rstwr_count", wbCount_out, 32'h0);

        // Fill x1..x31 with 0x100+i.
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("fill_count", wbCount_out, 32'd31);

        // Read every pair (i, 32-i) on the two ports.
        for (int i = 1; i < 32; i++) begin
            set_rd(1'b1, 5'(i), 1'b1, 5'(32 - i));
            #1;
            check($sformatf("pair_rs1_%0d", i), rs1Data_out, 32'h100 + 32'(i));
            check($sformatf("pair_rs2_%0d", 32 - i), rs2Data_out, 32'h100 + 32'(32 - i));
        end

        // Disabled port reads 0 while the other port is unaffected.
        set_rd(1'b0, 5'd9, 1'b1, 5'd9);
        #1;
        check("rs1_disabled", rs1Data_out, 32'h0);
        check("rs2_enabled", rs2Data_out, 32'h109);

        // Disabled write leaves storage and count unchanged.
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b0, 5'd4, 32'hCAFE_F00D);
        tick();
        set_rd(1'b1, 5'd4, 1'b0, 5'd0);
        #1;
        check("nowr_x4", rs1Data_out, 32'h104);
        check("nowr_count", wbCount_out, 32'd31);

        // Counter wrap: preload the counter to all-ones, then commit a write.
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        set_rd(1'b0, 5'd0, 1'b0, 5'd0);
        set_wr(1'b1, 5'd12, 32'h0BAD_F00D);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(1'b1, 5'd12, 1'b0, 5'd0);
        #1;
        check("wrap_count", wbCount_out, 32'h0);
        check("wrap_x12", rs1Data_out, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
